// File: rtl/myspi_regbank.sv
// SPI mode-0 slave register bank: R/W bit + address header followed by data words,
// with RW registers driven out to fabric logic and RO registers read back from it.
module myspi_regbank #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned N_RW     = 16,
  parameter int unsigned N_RO     = 16,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic                     theClock,
  input  logic                     theReset,
  input  logic                     MySPI_clk,
  input  logic                     MySPI_cs,
  input  logic                     MySPI_sdi,
  output logic                     MySPI_sdo,
  output logic [N_RW*DATA_W-1:0]   rw_regs,
  input  logic [N_RO*DATA_W-1:0]   ro_regs,
  output logic [N_RW-1:0]          wr_pulse,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int unsigned HDR_W = 1 + ADDR_W;
  localparam int unsigned MAXB  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAXB);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LOAD   = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                armed_q, armed_d;
  logic                err_d;
  logic                sdo_d;
  logic                busy_d;

  logic [1:0]          sclk_sync_q;
  logic                sclk_prev_q;
  logic [1:0]          cs_sync_q;
  logic [1:0]          sdi_sync_q;
  logic [1:0]          sync_ok_q;

  logic [DATA_W-1:0]   rw_q [N_RW];
  logic [N_RW-1:0]     wr_sel_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                sclk_rise_c;
  logic                cs_high_c;
  logic                sdi_c;
  logic                is_wr_c;
  logic [ADDR_W-1:0]   addr_c;

  // Two-flop synchronisers; sync_ok masks the reset values until the pipes hold real pin samples
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      sclk_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_sync_q   <= 2'b11;
      sdi_sync_q  <= 2'b00;
      sync_ok_q   <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], MySPI_clk};
      sclk_prev_q <= sclk_sync_q[1];
      cs_sync_q   <= {cs_sync_q[0], MySPI_cs};
      sdi_sync_q  <= {sdi_sync_q[0], MySPI_sdi};
      sync_ok_q   <= {sync_ok_q[0], 1'b1};
    end
  end

  assign sclk_rise_c = sclk_sync_q[1] & ~sclk_prev_q;
  assign cs_high_c   = cs_sync_q[1];
  assign sdi_c       = sdi_sync_q[1];
  assign is_wr_c     = hdr_q[HDR_W-1];
  assign addr_c      = hdr_q[ADDR_W-1:0];

  // Read mux: RW file, then RO inputs, anything above reads as zero
  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < N_RW; k++) begin
      if (32'(addr_c) == k) rd_data_c = rw_q[k];
    end
    for (int unsigned k = 0; k < N_RO; k++) begin
      if (32'(addr_c) == N_RW + k) rd_data_c = ro_regs[k*DATA_W +: DATA_W];
    end
  end

  // Write decode: only mapped RW addresses of a write frame, and a COMMIT always completes
  always_comb begin
    wr_sel_c = '0;
    for (int unsigned k = 0; k < N_RW; k++) begin
      wr_sel_c[k] = (state_q == COMMIT) && is_wr_c && (32'(addr_c) == k);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    shreg_d = shreg_q;
    armed_d = armed_q;
    err_d   = 1'b0;
    sdo_d   = 1'b0;
    busy_d  = 1'b0;

    if (cs_high_c && sync_ok_q[1]) armed_d = 1'b1;

    if (cs_high_c) begin
      state_d = IDLE;
      if ((state_q == ADDR || state_q == DATA) && cnt_q != '0) err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = ADDR;
            cnt_d   = '0;
            hdr_d   = '0;
            armed_d = 1'b0;
          end
        end
        ADDR: begin
          if (sclk_rise_c) begin
            hdr_d = {hdr_q[HDR_W-2:0], sdi_c};
            if (cnt_q == CNT_W'(HDR_W - 1)) begin
              state_d = LOAD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        LOAD: begin
          shreg_d = rd_data_c;
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          if (sclk_rise_c) begin
            shreg_d = {shreg_q[DATA_W-2:0], sdi_c};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d = COMMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          if (AUTO_INC != 0) begin
            hdr_d   = {is_wr_c, ADDR_W'(addr_c + ADDR_W'(1))};
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end

    // sdo is registered from next-state values so it tracks state/shreg without extra lag
    if (state_d == LOAD || state_d == DATA || state_d == COMMIT) sdo_d = shreg_d[DATA_W-1];
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hdr_q     <= '0;
      shreg_q   <= '0;
      armed_q   <= 1'b0;
      frame_err <= 1'b0;
      MySPI_sdo <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      shreg_q   <= shreg_d;
      armed_q   <= armed_d;
      frame_err <= err_d;
      MySPI_sdo <= sdo_d;
      busy      <= busy_d;
    end
  end

  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      for (int unsigned k = 0; k < N_RW; k++) rw_q[k] <= '0;
      wr_pulse <= '0;
    end else begin
      for (int unsigned k = 0; k < N_RW; k++) begin
        if (wr_sel_c[k]) rw_q[k] <= shreg_q;
      end
      wr_pulse <= wr_sel_c;
    end
  end

  for (genvar g = 0; g < int'(N_RW); g++) begin : g_pack
    assign rw_regs[g*DATA_W +: DATA_W] = rw_q[g];
  end

endmodule

// File: tb/tb_myspi_regbank.sv
// Directed bench for myspi_regbank: bit-banged SPI frames with hand-computed expectations.
module tb_myspi_regbank;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned N_RW   = 16;
  localparam int unsigned N_RO   = 16;

  logic                    theClock  = 1'b0;
  logic                    theReset  = 1'b0;
  logic                    MySPI_clk = 1'b0;
  logic                    MySPI_cs  = 1'b1;
  logic                    MySPI_sdi = 1'b0;
  logic                    MySPI_sdo;
  logic [N_RW*DATA_W-1:0]  rw_regs;
  logic [N_RO*DATA_W-1:0]  ro_regs;
  logic [N_RW-1:0]         wr_pulse;
  logic                    frame_err;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [N_RW];
  int fe_cnt = 0;
  int exp_pulse [N_RW];
  int exp_fe = 0;
  logic [N_RW*DATA_W-1:0] exp_rw = '0;
  logic [7:0] rx;

  myspi_regbank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RW(N_RW), .N_RO(N_RO), .AUTO_INC(1)
  ) dut (
    .theClock (theClock),
    .theReset (theReset),
    .MySPI_clk(MySPI_clk),
    .MySPI_cs (MySPI_cs),
    .MySPI_sdi(MySPI_sdi),
    .MySPI_sdo(MySPI_sdo),
    .rw_regs  (rw_regs),
    .ro_regs  (ro_regs),
    .wr_pulse (wr_pulse),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 theClock = ~theClock;

  // Count high cycles of every strobe so pulse width and multiplicity are both visible
  always @(negedge theClock) begin
    for (int k = 0; k < int'(N_RW); k++) if (wr_pulse[k]) pulse_cnt[k]++;
    if (frame_err) fe_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack_obs_pulses();
    logic [63:0] v = '0;
    for (int k = 0; k < int'(N_RW); k++) v[k*4 +: 4] = 4'(pulse_cnt[k]);
    return v;
  endfunction

  function automatic logic [63:0] pack_exp_pulses();
    logic [63:0] v = '0;
    for (int k = 0; k < int'(N_RW); k++) v[k*4 +: 4] = 4'(exp_pulse[k]);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge theClock);
  endtask

  task automatic expect_write(input int k, input logic [7:0] v);
    exp_rw[k*8 +: 8] = v;
    exp_pulse[k]++;
  endtask

  // One SPI word, MSB first; SCLK period 10 theClock; sdo sampled just before each rise
  task automatic spi_word(input logic [7:0] tx, input int nbits, output logic [7:0] rxo);
    rxo = '0;
    for (int i = 0; i < nbits; i++) begin
      tick(1);
      MySPI_sdi = tx[7-i];
      tick(4);
      rxo[7-i] = MySPI_sdo;
      MySPI_clk = 1'b1;
      tick(5);
      MySPI_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    tick(1);
    MySPI_cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    MySPI_cs = 1'b1;
    tick(8);
  endtask

  initial begin
    for (int k = 0; k < int'(N_RO); k++) ro_regs[k*8 +: 8] = 8'(8'hC0 + k);
    ro_regs[7:0] = 8'h5C;

    // Reset state
    tick(3);
    check("reset_rw_regs", rw_regs, 128'(exp_rw));
    check("reset_wr_pulse", 128'(wr_pulse), 128'(0));
    check("reset_frame_err", 128'(frame_err), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_sdo", 128'(MySPI_sdo), 128'(0));
    theReset = 1'b1;
    tick(6);

    // Single write 0x83, 0xA5
    cs_low();
    check("busy_in_frame", 128'(busy), 128'(1));
    spi_word(8'h83, 8, rx);
    spi_word(8'hA5, 8, rx);
    cs_high();
    expect_write(3, 8'hA5);
    check("write3_regs", rw_regs, 128'(exp_rw));
    check("write3_pulses", 128'(pack_obs_pulses()), 128'(pack_exp_pulses()));
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_sdo", 128'(MySPI_sdo), 128'(0));

    // Burst read from addr 16: RO reg 0 then RO reg 1
    cs_low();
    spi_word(8'h10, 8, rx);
    spi_word(8'h00, 8, rx);
    check("read_ro0", 128'(rx), 128'(8'h5C));
    spi_word(8'h00, 8, rx);
    check("read_ro1", 128'(rx), 128'(8'hC1));
    cs_high();
    check("read_no_side_effect", rw_regs, 128'(exp_rw));

    // Burst write regs 1..3
    cs_low();
    spi_word(8'h81, 8, rx);
    spi_word(8'h11, 8, rx);
    spi_word(8'h22, 8, rx);
    spi_word(8'h33, 8, rx);
    cs_high();
    expect_write(1, 8'h11);
    expect_write(2, 8'h22);
    expect_write(3, 8'h33);
    check("burst_regs", rw_regs, 128'(exp_rw));
    check("burst_pulses", 128'(pack_obs_pulses()), 128'(pack_exp_pulses()));

    // Burst from 0x7F: unmapped word dropped, address wraps to reg 0
    cs_low();
    spi_word(8'hFF, 8, rx);
    spi_word(8'h44, 8, rx);
    spi_word(8'h55, 8, rx);
    cs_high();
    expect_write(0, 8'h55);
    check("wrap_regs", rw_regs, 128'(exp_rw));
    check("wrap_pulses", 128'(pack_obs_pulses()), 128'(pack_exp_pulses()));

    // Write to an RO address is ignored
    cs_low();
    spi_word(8'h90, 8, rx);
    spi_word(8'hEE, 8, rx);
    cs_high();
    check("ro_write_regs", rw_regs, 128'(exp_rw));
    check("ro_write_pulses", 128'(pack_obs_pulses()), 128'(pack_exp_pulses()));

    // Unmapped read returns zero
    cs_low();
    spi_word(8'h40, 8, rx);
    spi_word(8'hFF, 8, rx);
    cs_high();
    check("read_unmapped", 128'(rx), 128'(0));

    // Partial data word: frame error, no write
    cs_low();
    spi_word(8'h82, 8, rx);
    spi_word(8'hAB, 5, rx);
    cs_high();
    exp_fe++;
    check("partial_frame_err", 128'(fe_cnt), 128'(exp_fe));
    check("partial_regs", rw_regs, 128'(exp_rw));
    check("partial_pulses", 128'(pack_obs_pulses()), 128'(pack_exp_pulses()));

    // Reset in the middle of a write to reg 4, CS kept low afterwards
    cs_low();
    spi_word(8'h84, 8, rx);
    spi_word(8'h99, 4, rx);
    tick(1);
    theReset = 1'b0;
    tick(3);
    exp_rw = '0;
    check("midreset_regs", rw_regs, 128'(exp_rw));
    theReset = 1'b1;
    tick(6);
    check("midreset_busy", 128'(busy), 128'(0));
    spi_word(8'h99, 4, rx);
    spi_word(8'h84, 8, rx);
    spi_word(8'h77, 8, rx);
    tick(4);
    check("stale_cs_regs", rw_regs, 128'(exp_rw));
    check("stale_cs_pulses", 128'(pack_obs_pulses()), 128'(pack_exp_pulses()));
    check("stale_cs_frame_err", 128'(fe_cnt), 128'(exp_fe));
    cs_high();

    // Fresh frame after CS toggled works normally
    cs_low();
    spi_word(8'h84, 8, rx);
    spi_word(8'h6B, 8, rx);
    cs_high();
    expect_write(4, 8'h6B);
    check("after_reset_regs", rw_regs, 128'(exp_rw));
    check("after_reset_pulses", 128'(pack_obs_pulses()), 128'(pack_exp_pulses()));

    // Read back reg 4 over SPI
    cs_low();
    spi_word(8'h04, 8, rx);
    spi_word(8'h00, 8, rx);
    cs_high();
    check("readback_reg4", 128'(rx), 128'(8'h6B));
    check("final_frame_err", 128'(fe_cnt), 128'(exp_fe));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
